spi_sub: RTL and testbench
==========================

# spi_sub

SPI subordinate receiver for the DDS collaboration design: the receiving end of the `spi_main` link (mode 0, MSB first, active-low chip select). It oversamples `sclk`/`mosi`/`csb` in the `sys_clk` domain, deserializes one `WORD_WIDTH`-bit word per chip-select frame, and presents it on a parallel bus with a one-cycle valid strobe. It is used as an on-chip loopback checker for `spi_main` and as the command input for DDS register writes.

## Interface
- `WORD_WIDTH`, default 16: bits per frame; also the `parallel_out` width.
- `sys_clk` input 1: system clock; all state is updated on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sclk` input 1: SPI clock, asynchronous to `sys_clk`; idles low.
- `mosi` input 1: serial data, asynchronous to `sys_clk`.
- `csb` input 1: active-low chip select, asynchronous to `sys_clk`.
- `parallel_out` output `WORD_WIDTH`: last correctly received word; held until the next good frame.
- `data_valid` output 1: one-cycle pulse when `parallel_out` updates.
- `frame_err` output 1: one-cycle pulse when a frame ends with a bit count other than `WORD_WIDTH`.
- `busy` output 1: high while the FSM is in SHIFT.

## Operation
- Synchronizers:
  - `sclk`, `mosi` and `csb` each pass through 2 flops (`_s1`, `_s2`).
  - `sclk` has a third flop (`_s3`) for edge detection.
  - Reset values: `csb` stages 0; `sclk` and `mosi` stages 0.
- An `sclk` rising edge is detected when `sclk_s2=1` and `sclk_s3=0`.
- `mosi_s2` is the sampled data bit. It has the same delay as `sclk_s2`, so it is aligned with the detected edge.
- FSM states: WAIT_IDLE (reset state), IDLE, SHIFT.
  - WAIT_IDLE -> IDLE when `csb_s2=1`. This rejects a frame already in progress at reset release.
  - IDLE -> SHIFT when `csb_s2=0`. On entry, the shift register and bit count are cleared.
  - In SHIFT, on each detected `sclk` rise: `shreg <= {shreg[WORD_WIDTH-2:0], mosi_s2}`, and the bit count increments.
  - The bit count saturates at `WORD_WIDTH+1`; width is `$clog2(WORD_WIDTH+2)`.
  - SHIFT -> IDLE when `csb_s2=1`:
    - If count == `WORD_WIDTH`: `parallel_out <= shreg` and `data_valid` pulses.
    - Otherwise (short frame, or overrun with more than `WORD_WIDTH` bits): `frame_err` pulses and `parallel_out` is unchanged.
- `sclk` edges outside SHIFT are ignored.
- `data_valid` and `frame_err` are never high in the same cycle.
- Reset values of outputs: `parallel_out` = 0, `data_valid` = 0, `frame_err` = 0, `busy` = 0. Internal: state = WAIT_IDLE, count = 0, `shreg` = 0.
- Reset mid-frame: the partial word is discarded with no pulse. The receiver then waits for `csb` high before accepting a new frame.

## Timing
- Input constraints, in `sys_clk` periods:
  - Each `sclk` high and low phase is ≥ 2.
  - `mosi` is stable from ≥ 2 before to ≥ 2 after each `sclk` rise.
  - `csb` falls ≥ 2 before the first `sclk` rise.
  - `csb` rises ≥ 2 after the last `sclk` rise.
  - `csb` high time between frames is ≥ 3.
  - Bench uses `sclk` = `sys_clk`/4.
- Frame-end latency: `csb` rise sampled by `sys_clk` edge k -> `csb_s2` high after edge k+1 -> `data_valid`/`frame_err` and `parallel_out` change on edge k+2, high for exactly one cycle.
- Frame-start latency: `busy` rises on edge k+2 after the `csb` fall is sampled at edge k, and falls on the same edge that produces the end-of-frame pulse.
- Bit capture: a bit is shifted on edge k+2 after the `sclk` rise is sampled at edge k.
- Simultaneous events: if the last `sclk` rise and the `csb` rise are detected in the same cycle, the `csb` rise wins and that `sclk` edge is not counted. The constraints above make this illegal; the behaviour is still deterministic.

## Test plan
- Reset check: assert `rst_n`=0 mid-simulation with random pins -> `parallel_out`=0, `data_valid`=0, `frame_err`=0, `busy`=0 immediately (asynchronous).
- Single frame, `WORD_WIDTH`=16:
  - Stimulus: send 16'hA5A5 MSB first, mode 0, `sclk` = `sys_clk`/4.
  - Response: exactly one `data_valid` pulse 2 edges after `csb` rises is sampled; `parallel_out`=16'hA5A5; `frame_err` never high.
- Back-to-back frames: 16'h04D8 then 16'hFFFF with `csb` high for 3 cycles between them -> two `data_valid` pulses; `parallel_out` = 16'h04D8 then 16'hFFFF.
- Short frame: 8 bits of 8'h3C after a good 16'h1234 -> one `frame_err` pulse, no `data_valid`, `parallel_out` stays 16'h1234.
- Overrun frame: 17 `sclk` rises -> one `frame_err` pulse; `parallel_out` unchanged.
- Reset during a frame:
  - Stimulus: pulse `rst_n` low after 5 bits while `csb` is low; finish that frame; then send 16'hBEEF.
  - Response: no pulse for the interrupted frame; `data_valid` with `parallel_out`=16'hBEEF.

Source files
------------

// File: rtl/spi_sub_if.sv
// rtl/spi_sub_if.sv - SPI pin and parallel-word bundle for the spi_sub receiver
`timescale 1ns/1ps

interface spi_sub_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  sclk;
    logic                  mosi;
    logic                  csb;
    logic [WORD_WIDTH-1:0] parallel_out;
    logic                  data_valid;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  sclk,
        input  mosi,
        input  csb,
        output parallel_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport master (
        output sclk,
        output mosi,
        output csb,
        input  parallel_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/spi_sub.sv
// rtl/spi_sub.sv - oversampling SPI mode-0 subordinate, one WORD_WIDTH word per csb frame
`timescale 1ns/1ps

module spi_sub #(
    parameter int WORD_WIDTH = 16
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    spi_sub_if.slave   bus
);
    localparam int CW = $clog2(WORD_WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;
    logic csb_s1, csb_s2;
    logic sclk_rise;

    state_t state_q, state_d;
    logic   start_frame, shift_en, end_good, end_bad;

    logic [WORD_WIDTH-1:0] shreg_q;
    logic [CW-1:0]         count_q;
    logic [WORD_WIDTH-1:0] parallel_q;
    logic                  data_valid_q;
    logic                  frame_err_q;

    // mosi_s2 shares sclk_s2's two-flop delay, so it is the bit aligned with the detected rise
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            csb_s1  <= 1'b0;
            csb_s2  <= 1'b0;
        end else begin
            sclk_s1 <= bus.sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= bus.mosi;
            mosi_s2 <= mosi_s1;
            csb_s1  <= bus.csb;
            csb_s2  <= csb_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // csb rise takes priority over a coincident sclk rise in SHIFT
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        end_good    = 1'b0;
        end_bad     = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (csb_s2) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!csb_s2) begin
                    state_d     = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (csb_s2) begin
                    state_d = IDLE;
                    if (count_q == CNT_FULL) begin
                        end_good = 1'b1;
                    end else begin
                        end_bad = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            count_q <= '0;
        end else if (start_frame) begin
            shreg_q <= '0;
            count_q <= '0;
        end else if (shift_en) begin
            shreg_q <= {shreg_q[WORD_WIDTH-2:0], mosi_s2};
            if (count_q != CNT_MAX) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            parallel_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= end_good;
            frame_err_q  <= end_bad;
            if (end_good) begin
                parallel_q <= shreg_q;
            end
        end
    end

    assign bus.parallel_out = parallel_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.busy         = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_sub.sv
// tb/tb_spi_sub.sv - table-driven and randomized frame checks for spi_sub against an event scoreboard
`timescale 1ns/1ps

module tb_spi_sub;
    localparam int W = 16;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    always #5 sys_clk = ~sys_clk;

    spi_sub_if #(.WORD_WIDTH(W)) bus ();

    spi_sub #(.WORD_WIDTH(W)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int           cyc;
        logic         err;
        logic [W-1:0] val;
    } ev_t;

    typedef struct {
        logic [31:0]  bits;
        int           nbits;
        int           gap;
        int           rst_at;
        logic         exp_valid;
        logic         exp_err;
        logic [W-1:0] exp_out;
    } vec_t;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  overlap  = 0;
    ev_t obs_q[$];
    ev_t exp_q[$];
    ev_t mon_e;
    logic [W-1:0] model_out = '0;
    vec_t vecs[11];

    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (bus.data_valid === 1'b1) begin
            mon_e.cyc = cyc; mon_e.err = 1'b0; mon_e.val = bus.parallel_out;
            obs_q.push_back(mon_e);
        end
        if (bus.frame_err === 1'b1) begin
            mon_e.cyc = cyc; mon_e.err = 1'b1; mon_e.val = bus.parallel_out;
            obs_q.push_back(mon_e);
        end
        if (bus.data_valid === 1'b1 && bus.frame_err === 1'b1) overlap = overlap + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_event(input int at, input logic err, input logic [W-1:0] val);
        ev_t e;
        e.cyc = at; e.err = err; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits, input int gap,
                              input int rst_at, output int end_cyc);
        bus.csb = 1'b0;
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_out",   bus.parallel_out, '0);
                check("rst_mid_busy",  bus.busy, 1'b0);
                check("rst_mid_valid", bus.data_valid, 1'b0);
                #1;
                rst_n = 1'b1;
            end
            if (i == 8) check("busy_mid_frame", bus.busy, (rst_at >= 0 && rst_at <= i) ? 1'b0 : 1'b1);
            bus.mosi = bits[nbits-1-i];
            tick(2);
            bus.sclk = 1'b1;
            tick(2);
            bus.sclk = 1'b0;
        end
        tick(2);
        bus.csb = 1'b1;
        end_cyc = cyc;
        tick(gap);
    endtask

    task automatic compare_events(input string tag);
        int n;
        tick(10);
        check({tag, "_ev_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_ev_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
            check({tag, "_ev_kind"},  obs_q[i].err, exp_q[i].err);
            check({tag, "_ev_value"}, obs_q[i].val, exp_q[i].val);
        end
        check({tag, "_held_out"}, bus.parallel_out, model_out);
        check({tag, "_busy_idle"}, bus.busy, 1'b0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec;
        int nb;
        logic [31:0] w;

        vecs[0]  = '{32'h0000A5A5, 16, 6, -1, 1'b1, 1'b0, 16'hA5A5};
        vecs[1]  = '{32'h000004D8, 16, 3, -1, 1'b1, 1'b0, 16'h04D8};
        vecs[2]  = '{32'h0000FFFF, 16, 6, -1, 1'b1, 1'b0, 16'hFFFF};
        vecs[3]  = '{32'h00001234, 16, 6, -1, 1'b1, 1'b0, 16'h1234};
        vecs[4]  = '{32'h0000003C,  8, 6, -1, 1'b0, 1'b1, 16'h1234};
        vecs[5]  = '{32'h0001ABCD, 17, 6, -1, 1'b0, 1'b1, 16'h1234};
        vecs[6]  = '{32'h00000000,  0, 6, -1, 1'b0, 1'b1, 16'h1234};
        vecs[7]  = '{32'h00007FFF, 15, 6, -1, 1'b0, 1'b1, 16'h1234};
        vecs[8]  = '{32'h00005A5A, 16, 6,  5, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{32'h0000BEEF, 16, 6, -1, 1'b1, 1'b0, 16'hBEEF};
        vecs[10] = '{32'h00000000, 16, 6, -1, 1'b1, 1'b0, 16'h0000};

        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.csb  = 1'b1;
        rst_n    = 1'b0;
        tick(3);
        check("reset_out",   bus.parallel_out, '0);
        check("reset_valid", bus.data_valid, 1'b0);
        check("reset_err",   bus.frame_err, 1'b0);
        check("reset_busy",  bus.busy, 1'b0);
        rst_n = 1'b1;
        tick(4);

        foreach (vecs[v]) begin
            send_frame(vecs[v].bits, vecs[v].nbits, vecs[v].gap, vecs[v].rst_at, ec);
            if (vecs[v].exp_valid || vecs[v].exp_err)
                expect_event(ec + 4, vecs[v].exp_err, vecs[v].exp_out);
            model_out = vecs[v].exp_out;
        end
        compare_events("table");

        for (int f = 0; f < 30; f++) begin
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : W;
            w  = $urandom;
            send_frame(w, nb, int'($urandom_range(3, 8)), -1, ec);
            if (nb == W) begin
                model_out = w[W-1:0];
                expect_event(ec + 4, 1'b0, model_out);
            end else begin
                expect_event(ec + 4, 1'b1, model_out);
            end
        end
        compare_events("random");

        bus.sclk = 1'($urandom);
        bus.mosi = 1'($urandom);
        bus.csb  = 1'($urandom);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out",   bus.parallel_out, '0);
        check("async_rst_valid", bus.data_valid, 1'b0);
        check("async_rst_err",   bus.frame_err, 1'b0);
        check("async_rst_busy",  bus.busy, 1'b0);
        bus.csb  = 1'b1;
        bus.sclk = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_out = '0;
        tick(4);
        send_frame(32'h0000C3A1, 16, 6, -1, ec);
        model_out = 16'hC3A1;
        expect_event(ec + 4, 1'b0, model_out);
        compare_events("post_reset");

        check("no_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
